mnist_sample_feeder: RTL

- Byte-stream transmitter that builds the 794-bit training vector for the ten per-class pseudo-linear learners.
- Vector layout: bits [793:10] hold 784 binary pixels; bits [9:0] hold the one-hot class label.
- Accepts a labelled frame over a valid/ready byte interface, assembles it, then presents it for a programmable number of cycles.
- Drives all-zero between samples. With an all-zero vector every learner computes result=0 with y=0, so its parameters are frozen.

---
 rtl/mnist_pkg.sv | 24 ++
 rtl/mnist_frame_assembler.sv | 83 ++++++++
 rtl/mnist_sample_feeder.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/mnist_pkg.sv
// Shared constants, FSM state type and label encoder for the MNIST sample feeder.
// Vector layout: [793:10] = 784 binary pixels, [9:0] = one-hot class label.
// Used by mnist_frame_assembler and mnist_sample_feeder.
package mnist_pkg;

  localparam int IMG_PIX         = 784;
  localparam int NUM_CLASS       = 10;
  localparam int VEC_W           = 794;
  localparam int LBL_LSB         = 0;
  localparam int PIX_LSB         = 10;
  localparam int BYTES_PER_FRAME = 99;

  typedef enum logic [1:0] {IDLE, LOAD, DROP, PRESENT} feeder_state_t;

  // One-hot class encoding; labels above 9 give an all-zero vector.
  function automatic logic [NUM_CLASS-1:0] onehot10(input logic [3:0] label);
    logic [NUM_CLASS-1:0] oh;
    for (int i = 0; i < NUM_CLASS; i++) begin
      oh[i] = (label == 4'(i));
    end
    return oh;
  endfunction

endpackage

// File: rtl/mnist_frame_assembler.sv
// Frame assembler: counts the 99 bytes of a frame, checks the label, collects pixels.
// Latency: frame_done_o and pix_o are combinational on the last-byte handshake.
// Backpressure: none of its own; it only sees bytes the top has already accepted.
module mnist_frame_assembler
  import mnist_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               acc_i,
  input  logic [7:0]         byte_i,
  output logic               label_ok_o,
  output logic               label_bad_o,
  output logic               frame_done_o,
  output logic               drop_done_o,
  output logic               busy_d_o,
  output logic               drop_d_o,
  output logic               label_err_o,
  output logic [3:0]         label_o,
  output logic [IMG_PIX-1:0] pix_o
);

  localparam int LAST_IDX = BYTES_PER_FRAME - 1;

  logic [6:0]           byte_cnt_q, byte_cnt_d;
  logic                 drop_q, drop_d;
  logic [3:0]           label_q, label_d;
  logic                 label_err_q;
  // The final pixel byte is never stored: it is merged straight into pix_o.
  logic [IMG_PIX-9:0]   pix_q;
  logic                 first_byte, last_byte;
  logic [9:0]           wr_off;

  assign first_byte = acc_i && (byte_cnt_q == 7'd0);
  assign last_byte  = acc_i && (byte_cnt_q == 7'(LAST_IDX));
  assign wr_off     = {byte_cnt_q - 7'd1, 3'b000};

  // Frame bookkeeping: label check, byte counter and drop flag next state.
  always_comb begin
    label_ok_o   = first_byte && (byte_i <= 8'd9);
    label_bad_o  = first_byte && (byte_i > 8'd9);
    frame_done_o = last_byte && !drop_q;
    drop_done_o  = last_byte && drop_q;
    byte_cnt_d   = byte_cnt_q;
    drop_d       = drop_q;
    label_d      = label_q;
    if (last_byte) begin
      byte_cnt_d = 7'd0;
      drop_d     = 1'b0;
    end else if (acc_i) begin
      byte_cnt_d = byte_cnt_q + 7'd1;
    end
    if (label_bad_o) drop_d  = 1'b1;
    if (label_ok_o)  label_d = byte_i[3:0];
    busy_d_o = (byte_cnt_d != 7'd0);
    drop_d_o = drop_d;
  end

  // Counter, label and pixel storage; pixels are wiped at every frame boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt_q  <= '0;
      drop_q      <= 1'b0;
      label_q     <= '0;
      label_err_q <= 1'b0;
      pix_q       <= '0;
    end else begin
      byte_cnt_q  <= byte_cnt_d;
      drop_q      <= drop_d;
      label_q     <= label_d;
      label_err_q <= label_bad_o;
      if (last_byte) begin
        pix_q <= '0;
      end else if (acc_i && (byte_cnt_q != 7'd0) && !drop_q) begin
        pix_q[wr_off +: 8] <= byte_i;
      end
    end
  end

  assign label_err_o = label_err_q;
  assign label_o     = label_q;
  assign pix_o       = {byte_i, pix_q};

endmodule

// File: rtl/mnist_sample_feeder.sv
// Sample feeder: assembles 99-byte labelled frames and presents each 794-bit vector HOLD_CYCLES cycles.
// Latency: sample visible the cycle after the last-byte handshake; all-zero between samples.
// Backpressure: in_ready low while presenting (MNIST_FEEDER_DOUBLE_BUF_EN: only while a frame is pending).
module mnist_sample_feeder
  import mnist_pkg::*;
#(
  parameter int HOLD_CYCLES = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic [VEC_W-1:0] image_data,
  output logic             sample_valid,
  output logic             label_err,
  output logic [CNT_W-1:0] sample_cnt
);

  localparam int                HOLD_W    = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_CYCLES - 1);

  feeder_state_t      state_q, state_d;
  logic [VEC_W-1:0]   image_q, new_vec, load_vec;
  logic               valid_q;
  logic [HOLD_W-1:0]  hold_cnt_q;
  logic [CNT_W-1:0]   sample_cnt_q;
  logic               acc, hold_end, load_new, load_pend, clear_out;
  logic               label_ok, label_bad, frame_done, drop_done, asm_busy_d, asm_drop_d;
  logic [3:0]         label;
  logic [IMG_PIX-1:0] pix;

  assign acc      = in_valid && in_ready;
  assign hold_end = (state_q == PRESENT) && (hold_cnt_q == '0);

  mnist_frame_assembler u_asm (
    .clk          (clk),
    .rst_n        (rst_n),
    .acc_i        (acc),
    .byte_i       (in_data),
    .label_ok_o   (label_ok),
    .label_bad_o  (label_bad),
    .frame_done_o (frame_done),
    .drop_done_o  (drop_done),
    .busy_d_o     (asm_busy_d),
    .drop_d_o     (asm_drop_d),
    .label_err_o  (label_err),
    .label_o      (label),
    .pix_o        (pix)
  );

  always_comb begin
    new_vec                         = '0;
    new_vec[PIX_LSB +: IMG_PIX]     = pix;
    new_vec[LBL_LSB +: NUM_CLASS]   = onehot10(label);
  end

`ifdef MNIST_FEEDER_DOUBLE_BUF_EN
  logic             pend_q, pend_set;
  logic [VEC_W-1:0] pend_vec_q;

  // Second buffer: catches a frame completed mid-presentation until it can be shown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q     <= 1'b0;
      pend_vec_q <= '0;
    end else if (pend_set) begin
      pend_q     <= 1'b1;
      pend_vec_q <= new_vec;
    end else if (load_pend) begin
      pend_q     <= 1'b0;
    end
  end

  assign load_vec = load_pend ? pend_vec_q : new_vec;
`else
  assign load_vec = new_vec;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state; leaving PRESENT resumes whatever frame phase the assembler is in.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (label_ok) state_d = LOAD;
               else if (label_bad) state_d = DROP;
      LOAD:    if (frame_done) state_d = PRESENT;
      DROP:    if (drop_done) state_d = IDLE;
      PRESENT: if (hold_end && !load_new && !load_pend)
                 state_d = asm_busy_d ? (asm_drop_d ? DROP : LOAD) : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs and datapath strobes decoded from state.
  always_comb begin
    load_new  = frame_done && ((state_q != PRESENT) || hold_end);
`ifdef MNIST_FEEDER_DOUBLE_BUF_EN
    in_ready  = !pend_q;
    load_pend = hold_end && pend_q;
    pend_set  = frame_done && (state_q == PRESENT) && !hold_end;
`else
    in_ready  = (state_q != PRESENT);
    load_pend = 1'b0;
`endif
    clear_out = hold_end && !load_new && !load_pend;
  end

  // Output register, hold countdown and completed-presentation counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      image_q      <= '0;
      valid_q      <= 1'b0;
      hold_cnt_q   <= '0;
      sample_cnt_q <= '0;
    end else begin
      if (load_new || load_pend) begin
        image_q    <= load_vec;
        valid_q    <= 1'b1;
        hold_cnt_q <= HOLD_INIT;
      end else if (clear_out) begin
        image_q    <= '0;
        valid_q    <= 1'b0;
      end else if (state_q == PRESENT) begin
        hold_cnt_q <= hold_cnt_q - 1'b1;
      end
      if (hold_end) sample_cnt_q <= sample_cnt_q + 1'b1;
    end
  end

  assign image_data   = image_q;
  assign sample_valid = valid_q;
  assign sample_cnt   = sample_cnt_q;

endmodule
